// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a sync FIFO into fixed-length valid/ready bursts (optional BURST_GAP_EN)
`timescale 1ns/1ps
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
`ifdef BURST_GAP_EN
    ,
    parameter int GAP_CYCLES = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LEN_C  = CW'(BURST_LEN);
    localparam logic [CW-1:0] LAST_C = CW'(BURST_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
`ifdef BURST_GAP_EN
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    logic [GW-1:0]         r_gap_cnt;
`endif

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_buf [3];
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [CW-1:0]         r_req_cnt;
    logic [CW-1:0]         r_sent_cnt;

    logic [2:0]            w_pending;
    logic                  w_hs;
    logic                  w_done;

    function automatic logic [1:0] f_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Read gating uses only registered occupancy, so m_ready never reaches fifo_rd_en.
    assign w_pending  = {1'b0, r_occ} + {2'b00, r_inflight};
    assign fifo_rd_en = (r_state == ST_BURST) && !fifo_empty
                        && (r_req_cnt < LEN_C) && (w_pending < 3'd3);
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf[r_head];
    assign m_last     = m_valid && (r_sent_cnt == LAST_C);
    assign busy       = (r_state != ST_IDLE);
    assign w_hs       = m_valid && m_ready;
    assign w_done     = w_hs && m_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) r_buf[i] <= '0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight) begin
                r_buf[r_tail] <= fifo_rd_data;
                r_tail        <= f_inc(r_tail);
            end
            if (w_hs) r_head <= f_inc(r_head);
            case ({r_inflight, w_hs})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req_cnt  <= '0;
            r_sent_cnt <= '0;
`ifdef BURST_GAP_EN
            r_gap_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_cnt  <= '0;
                    r_sent_cnt <= '0;
                    if (!fifo_empty) r_state <= ST_BURST;
                end
                ST_BURST: begin
                    if (fifo_rd_en) r_req_cnt  <= r_req_cnt + 1'b1;
                    if (w_hs)       r_sent_cnt <= r_sent_cnt + 1'b1;
                    if (w_done) begin
                        r_req_cnt  <= '0;
                        r_sent_cnt <= '0;
`ifdef BURST_GAP_EN
                        r_gap_cnt  <= '0;
                        r_state    <= ST_GAP;
`else
                        r_state    <= ST_IDLE;
`endif
                    end
                end
`ifdef BURST_GAP_EN
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) r_state <= ST_IDLE;
                    else                       r_gap_cnt <= r_gap_cnt + 1'b1;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed table-driven bench for fifo_burst_reader
`timescale 1ns/1ps
module tb_fifo_burst_reader;

`ifdef BURST_GAP_EN
    localparam int EXP_GAP = 3;
`else
    localparam int EXP_GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_en;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rp % 16];
            rp <= rp + 1;
        end
    end

`ifdef BURST_GAP_EN
    fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .GAP_CYCLES(3)) dut (
`else
    fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
`endif
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy));

    typedef struct {
        int         tst;
        logic [7:0] exp_d;
        logic       exp_l;
    } vec_t;
    vec_t vt[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int outst = 0;
    int max_out = 0;
    int stab_err = 0;
    int idle_viol = 0;
    int first_rd = -1;
    int first_v = -1;
    int gap_busy = 0;
    int gap_idle = 0;
    bit chk_idle = 0;
    bit gap_arm = 0;
    bit gap_run = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;
    logic [7:0] rx_d[$];
    logic       rx_l[$];
    int         rx_c[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            outst = 0;
            prev_stall = 1'b0;
        end else begin
            if (chk_idle && (fifo_rd_en || m_valid || busy)) idle_viol++;
            if (prev_stall && !(m_valid && m_data == prev_d && m_last == prev_l)) stab_err++;
            if (fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (m_valid && first_v < 0) first_v = cyc;
            if (gap_run) begin
                if (fifo_rd_en) gap_run = 0;
                else if (busy)  gap_busy++;
                else            gap_idle++;
            end
            if (fifo_rd_en && !fifo_empty) outst++;
            if (m_valid && m_ready) begin
                outst--;
                rx_d.push_back(m_data);
                rx_l.push_back(m_last);
                rx_c.push_back(cyc);
                if (m_last && gap_arm) begin
                    gap_arm = 0;
                    gap_run = 1;
                end
            end
            if (outst > max_out) max_out = outst;
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int t, input logic [7:0] d, input logic l);
        vec_t v;
        v.tst = t; v.exp_d = d; v.exp_l = l;
        vt.push_back(v);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp % 16] = d;
        wp++;
    endtask

    task automatic clear_rx();
        rx_d.delete(); rx_l.delete(); rx_c.delete();
    endtask

    task automatic wait_rx(input int n, input int lim);
        int c = 0;
        while (rx_d.size() < n && c < lim) begin
            @(posedge clk); #1;
            c++;
        end
        if (rx_d.size() < n) chk("timeout_rx", rx_d.size(), n);
    endtask

    task automatic check_beats(input int t);
        int k = 0;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].tst == t) begin
                if (k < rx_d.size()) begin
                    chk($sformatf("t%0d_data[%0d]", t, k), int'(rx_d[k]), int'(vt[i].exp_d));
                    chk($sformatf("t%0d_last[%0d]", t, k), int'(rx_l[k]), int'(vt[i].exp_l));
                end else begin
                    chk($sformatf("t%0d_missing[%0d]", t, k), 0, 1);
                end
                k++;
            end
        end
        chk($sformatf("t%0d_count", t), rx_d.size(), k);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_rd_en"}, int'(fifo_rd_en), 0);
        chk({nm, "_valid"}, int'(m_valid), 0);
        chk({nm, "_last"},  int'(m_last), 0);
        chk({nm, "_busy"},  int'(busy), 0);
        chk({nm, "_data"},  int'(m_data), 0);
    endtask

    initial begin
        int nb;
        bit [3:0] pat;

        add(2, 8'h10, 0); add(2, 8'h11, 0); add(2, 8'h12, 0); add(2, 8'h13, 1);
        add(2, 8'h14, 0); add(2, 8'h15, 0); add(2, 8'h16, 0); add(2, 8'h17, 1);
        add(3, 8'hA0, 0); add(3, 8'hA1, 0); add(3, 8'hA2, 0); add(3, 8'hA3, 1);
        add(4, 8'h40, 0); add(4, 8'h41, 0); add(4, 8'h42, 0); add(4, 8'h43, 1);
        add(4, 8'h44, 0); add(4, 8'h45, 0); add(4, 8'h46, 0); add(4, 8'h47, 1);
        add(5, 8'h54, 0); add(5, 8'h55, 0); add(5, 8'h56, 0); add(5, 8'h57, 1);

        // 1: reset values, then idle with an empty FIFO
        #2;
        chk_reset_outs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk_idle = 1;
        repeat (20) @(posedge clk);
        #1;
        chk_idle = 0;
        chk("idle_activity", idle_viol, 0);

        // 2: two full bursts at full rate
        clear_rx();
        first_rd = -1; first_v = -1;
        gap_busy = 0; gap_idle = 0; gap_arm = 1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        wait_rx(8, 200);
        check_beats(2);
        chk("first_latency", first_v - first_rd, 2);
        nb = 0;
        if (rx_c.size() == 8) begin
            for (int i = 0; i < 7; i++)
                if (i != 3 && rx_c[i+1] - rx_c[i] != 1) nb++;
        end else nb = -1;
        chk("back_to_back_gaps", nb, 0);
        chk("gap_busy_cycles", gap_busy, EXP_GAP);
        chk("gap_idle_cycles", gap_idle, 1);
        repeat (8) @(posedge clk);
        #1;

        // 3: burst waits for late data
        clear_rx();
        push(8'hA0); push(8'hA1);
        repeat (10) @(posedge clk);
        #1;
        push(8'hA2);
        repeat (10) @(posedge clk);
        #1;
        chk("starved_count", rx_d.size(), 3);
        chk("starved_busy", int'(busy), 1);
        chk("starved_no_last", int'(m_last), 0);
        push(8'hA3);
        wait_rx(4, 50);
        check_beats(3);
        repeat (8) @(posedge clk);
        #1;

        // 4: backpressure with m_ready pattern 1,0,0,1
        clear_rx();
        max_out = 0;
        pat = 4'b1001;
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        for (int c = 0; c < 300 && rx_d.size() < 8; c++) begin
            m_ready = pat[c % 4];
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        check_beats(4);
        chk("max_outstanding_le3", int'(max_out <= 3), 1);
        chk("stall_stability", stab_err, 0);
        repeat (8) @(posedge clk);
        #1;

        // 5: asynchronous reset after two beats of a burst
        clear_rx();
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        wait_rx(2, 100);
        chk("pre_reset_beats", rx_d.size(), 2);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_rx();
        wait_rx(4, 100);
        check_beats(5);
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_extra", rx_d.size(), 4);
        chk("final_stability", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
